// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // The prescaler advances only while the stopwatch is timing.
    function automatic logic is_counting(input state_t st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw pushbutton conditioning: two-flop synchronizer, level debouncer and a
// registered one-cycle press pulse on every accepted rising level.
module btn_conditioner #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic          press_r;
    logic [CW-1:0] deb_cnt_r;

    // Synchronize, debounce and convert an accepted rising level into a pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
            deb_cnt_r <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            // Count consecutive samples that disagree with the accepted level.
            if (sync2_r != level_r) begin
                if (deb_cnt_r == CW'(DEB_CYCLES - 1)) begin
                    level_r   <= sync2_r;
                    deb_cnt_r <= '0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + CW'(1);
                end
            end else begin
                deb_cnt_r <= '0;
            end
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button handling, run/pause/lap/reset FSM,
// count-tick prescaler, lap capture and live/lap display selection.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 6000,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               btn_start,
    input  logic               btn_lap,
    input  logic [DIGIT_W-1:0] cnt_ones,
    input  logic [DIGIT_W-1:0] cnt_tens,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic               running,
    output logic               disp_sel,
    output logic [DIGIT_W-1:0] disp_ones,
    output logic [DIGIT_W-1:0] disp_tens
);

    localparam int PW = $clog2(TICK_DIV);

    state_t             state_r;
    logic [PW-1:0]      p_r;
    logic [DIGIT_W-1:0] lap_ones_r;
    logic [DIGIT_W-1:0] lap_tens_r;
    logic               cnt_en_r;
    logic               cnt_clr_r;
    logic               running_r;
    logic               disp_sel_r;
    logic               start_press_s;
    logic               lap_press_s;
    logic               counting_s;
    logic               tick_due_s;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start_btn (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_start),
        .press (start_press_s)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_lap_btn (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_lap),
        .press (lap_press_s)
    );

    assign counting_s = is_counting(state_r);
    assign tick_due_s = counting_s && (p_r == PW'(TICK_DIV - 1));

    // Control FSM with prescaler, lap registers and registered status outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            p_r        <= '0;
            lap_ones_r <= '0;
            lap_tens_r <= '0;
            cnt_en_r   <= 1'b0;
            cnt_clr_r  <= 1'b1;
            running_r  <= 1'b0;
            disp_sel_r <= 1'b0;
        end else begin
            cnt_clr_r <= 1'b0;
            // Tick follows the current state, so a tick due while leaving for PAUSE still fires.
            cnt_en_r  <= tick_due_s;
            if (tick_due_s) begin
                p_r <= '0;
            end else if (counting_s) begin
                p_r <= p_r + PW'(1);
            end else begin
                p_r <= p_r;
            end
            // Start is tested first everywhere, so a simultaneous lap press is dropped.
            case (state_r)
                ST_IDLE: begin
                    if (start_press_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_press_s) begin
                        state_r   <= ST_PAUSE;
                        running_r <= 1'b0;
                    end else if (lap_press_s) begin
                        state_r    <= ST_LAP;
                        disp_sel_r <= 1'b1;
                        lap_ones_r <= cnt_ones;
                        lap_tens_r <= cnt_tens;
                    end
                end
                ST_LAP: begin
                    if (start_press_s) begin
                        state_r    <= ST_PAUSE;
                        running_r  <= 1'b0;
                        disp_sel_r <= 1'b0;
                    end else if (lap_press_s) begin
                        state_r    <= ST_RUN;
                        disp_sel_r <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_press_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else if (lap_press_s) begin
                        state_r    <= ST_IDLE;
                        p_r        <= '0;
                        lap_ones_r <= '0;
                        lap_tens_r <= '0;
                        cnt_clr_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    running_r  <= 1'b0;
                    disp_sel_r <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_en    = cnt_en_r;
    assign cnt_clr   = cnt_clr_r;
    assign running   = running_r;
    assign disp_sel  = disp_sel_r;
    assign disp_ones = disp_sel_r ? lap_ones_r : cnt_ones;
    assign disp_tens = disp_sel_r ? lap_tens_r : cnt_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized
// button activity, checked against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] cnt_ones = 4'd0;
    logic [3:0] cnt_tens = 4'd0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic       disp_sel;
    logic [3:0] disp_ones;
    logic [3:0] disp_tens;
    logic [11:0] obs_w;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: stopwatch mode, prescaler phase, lap memory, pulse outputs.
    int         m_mode;
    int         m_p;
    logic [3:0] m_lo;
    logic [3:0] m_lt;
    bit         m_en;
    bit         m_clr;
    // Per-button model: raw delay line, run of identical samples, level, press delay.
    int b_d1[2];
    int b_d2[2];
    int b_runv[2];
    int b_runl[2];
    int b_lvl[2];
    int b_rd1[2];
    int b_rd2[2];

    stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .cnt_ones  (cnt_ones),
        .cnt_tens  (cnt_tens),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .disp_sel  (disp_sel),
        .disp_ones (disp_ones),
        .disp_tens (disp_tens)
    );

    always #5 clk = ~clk;

    assign obs_w = {cnt_en, cnt_clr, running, disp_sel, disp_tens, disp_ones};

    task automatic model_reset();
        m_mode = M_IDLE; m_p = 0; m_lo = 4'd0; m_lt = 4'd0; m_en = 1'b0; m_clr = 1'b1;
        for (int b = 0; b < 2; b++) begin
            b_d1[b] = 0; b_d2[b] = 0; b_runv[b] = 0; b_runl[b] = 0;
            b_lvl[b] = 0; b_rd1[b] = 0; b_rd2[b] = 0;
        end
    endtask

    task automatic model_edge(input logic rs, input logic rl, input logic [3:0] co, input logic [3:0] ct);
        bit pr [2];
        bit counting;
        for (int b = 0; b < 2; b++) begin
            int samp;
            int raw;
            raw = (b == 0) ? int'(rs) : int'(rl);
            pr[b] = (b_rd2[b] != 0);
            b_rd2[b] = b_rd1[b];
            samp = b_d2[b];
            b_d2[b] = b_d1[b];
            b_d1[b] = raw;
            if (samp == b_runv[b]) b_runl[b] = b_runl[b] + 1;
            else begin b_runv[b] = samp; b_runl[b] = 1; end
            b_rd1[b] = 0;
            if (b_runl[b] >= DB && b_runv[b] != b_lvl[b]) begin
                b_lvl[b] = b_runv[b];
                b_rd1[b] = b_runv[b];
            end
        end
        counting = (m_mode == M_RUN) || (m_mode == M_LAP);
        m_en  = counting && (m_p == TD - 1);
        m_clr = 1'b0;
        if (counting) m_p = (m_p + 1) % TD;
        if (pr[0]) begin
            m_mode = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
        end else if (pr[1]) begin
            case (m_mode)
                M_RUN:   begin m_mode = M_LAP; m_lo = co; m_lt = ct; end
                M_LAP:   m_mode = M_RUN;
                M_PAUSE: begin m_mode = M_IDLE; m_p = 0; m_lo = 4'd0; m_lt = 4'd0; m_clr = 1'b1; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic sel;
        logic run;
        sel = (m_mode == M_LAP);
        run = (m_mode == M_RUN) || (m_mode == M_LAP);
        return {m_en, m_clr, run, sel, sel ? m_lt : cnt_tens, sel ? m_lo : cnt_ones};
    endfunction

    // One clock: capture the inputs the DUT will see, advance the model, settle.
    task automatic step();
        logic rs, rl, in_rst;
        logic [3:0] co, ct;
        rs = btn_start; rl = btn_lap; co = cnt_ones; ct = cnt_tens; in_rst = clr;
        @(posedge clk);
        if (in_rst) model_reset();
        else model_edge(rs, rl, co, ct);
        #1;
    endtask

    task automatic apply_reset();
        clr = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
        repeat (3) step();
        clr = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clr = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cnt_ones = 4'($urandom_range(9, 0));
            cnt_tens = 4'($urandom_range(5, 0));
            step();
            n_cmp++;
            if ({cnt_clr, cnt_en, disp_sel, running} !== 4'b1000) begin
                n_fail++; $display("FAIL reset_hold cyc%0d: got %b want 1000", c, {cnt_clr, cnt_en, disp_sel, running});
            end
            n_cmp++;
            if ({disp_tens, disp_ones} !== {cnt_tens, cnt_ones}) begin
                n_fail++; $display("FAIL reset_disp cyc%0d: got %h want %h", c, {disp_tens, disp_ones}, {cnt_tens, cnt_ones});
            end
        end
        clr = 1'b0;
        step();
        n_cmp++;
        if ({cnt_clr, cnt_en, disp_sel, running} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release: got %b want 0000", {cnt_clr, cnt_en, disp_sel, running});
        end
        n_cmp++;
        if (obs_w !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h want %h", obs_w, exp_vec());
        end
    endtask

    task automatic test_start();
        int run_e;
        int en_q[$];
        run_e = 0;
        btn_start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e == 13) btn_start = 1'b0;
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL start edge%0d: got %h want %h", e, obs_w, exp_vec());
            end
            if (running && run_e == 0) run_e = e;
            if (cnt_en) en_q.push_back(e);
        end
        n_cmp++;
        if (run_e !== 8) begin
            n_fail++; $display("FAIL start_latency: running rose at edge %0d want 8", run_e);
        end
        n_cmp++;
        if (en_q.size() != 3 || en_q[0] != 18 || en_q[1] != 28 || en_q[2] != 38) begin
            n_fail++; $display("FAIL start_ticks: got %0d ticks first %0d want 3 at 18/28/38",
                               en_q.size(), (en_q.size() > 0) ? en_q[0] : -1);
        end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        apply_reset();
        for (int c = 0; c < 45; c++) begin
            btn_start = (c < 30) && ((c % 5) < 3);
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL bounce cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
            seen += int'(running) + int'(cnt_en);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL bounce_ignored: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_lap();
        int en_obs, en_exp;
        en_obs = 0; en_exp = 0;
        apply_reset();
        cnt_tens = 4'd2; cnt_ones = 4'd5;
        btn_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) btn_start = 1'b0;
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL lap_start cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
        end
        cnt_tens = 4'd2; cnt_ones = 4'd7; btn_lap = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 7) btn_lap = 1'b0;
            if (c == 10) cnt_ones = 4'd8;
            if (c == 14) cnt_ones = 4'd9;
            if (c == 18) begin cnt_tens = 4'd3; cnt_ones = 4'd0; end
            if (c == 30) cnt_ones = 4'd1;
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL lap_hold cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
            if (c >= 8) begin
                n_cmp++;
                if ({disp_sel, disp_tens, disp_ones} !== 9'h127) begin
                    n_fail++; $display("FAIL lap_frozen cyc%0d: got %h want 127", c, {disp_sel, disp_tens, disp_ones});
                end
                en_obs += int'(cnt_en);
                en_exp += int'(m_en);
            end
        end
        n_cmp++;
        if (en_obs !== en_exp || en_obs < 3) begin
            n_fail++; $display("FAIL lap_ticks: got %0d want %0d", en_obs, en_exp);
        end
        btn_lap = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 7) btn_lap = 1'b0;
            cnt_ones = 4'($urandom_range(9, 0));
            cnt_tens = 4'($urandom_range(5, 0));
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL lap_release cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
            if (c >= 8) begin
                n_cmp++;
                if ({disp_sel, disp_tens, disp_ones} !== {1'b0, cnt_tens, cnt_ones}) begin
                    n_fail++; $display("FAIL lap_live cyc%0d: got %h want %h", c, {disp_sel, disp_tens, disp_ones}, {1'b0, cnt_tens, cnt_ones});
                end
            end
        end
    endtask

    task automatic test_pause();
        bit ph_lap [5];
        ph_lap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 40 && !(m_p == 8 && m_mode == M_RUN); c++) begin
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL pause_wait cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
        end
        for (int ph = 0; ph < 5; ph++) begin
            int run_c, tick_c, clr_n, en_late;
            run_c = 0; tick_c = 0; clr_n = 0; en_late = 0;
            if (ph_lap[ph]) btn_lap = 1'b1;
            else btn_start = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                if (c == 7) begin btn_start = 1'b0; btn_lap = 1'b0; end
                step();
                n_cmp++;
                if (obs_w !== exp_vec()) begin
                    n_fail++; $display("FAIL pause_ph%0d cyc%0d: got %h want %h", ph, c, obs_w, exp_vec());
                end
                if (running && run_c == 0) run_c = c;
                if (cnt_en && tick_c == 0) tick_c = c;
                clr_n += int'(cnt_clr);
                if (c > 8) en_late += int'(cnt_en);
            end
            n_cmp++;
            case (ph)
                0, 2: if (running !== 1'b0 || en_late !== 0) begin
                    n_fail++; $display("FAIL pause_hold ph%0d: running %b ticks %0d want 0/0", ph, running, en_late);
                end
                1: if (run_c !== 8 || tick_c - run_c !== 4) begin
                    n_fail++; $display("FAIL pause_resume: run@%0d tick@%0d want 8/12", run_c, tick_c);
                end
                3: if (clr_n !== 1 || running !== 1'b0) begin
                    n_fail++; $display("FAIL pause_reset: cnt_clr cycles %0d running %b want 1/0", clr_n, running);
                end
                default: if (run_c !== 8 || tick_c !== 18) begin
                    n_fail++; $display("FAIL pause_fresh: run@%0d tick@%0d want 8/18", run_c, tick_c);
                end
            endcase
        end
    endtask

    task automatic test_simul();
        btn_start = 1'b1; btn_lap = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            if (c == 7) begin btn_start = 1'b0; btn_lap = 1'b0; end
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL simul cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
        end
        n_cmp++;
        if ({running, disp_sel, cnt_clr} !== 3'b000) begin
            n_fail++; $display("FAIL simul_pause: got %b want 000", {running, disp_sel, cnt_clr});
        end
    endtask

    task automatic test_clr_lap();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) btn_start = 1'b1;
            else btn_lap = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                if (c == 7) begin btn_start = 1'b0; btn_lap = 1'b0; end
                step();
                n_cmp++;
                if (obs_w !== exp_vec()) begin
                    n_fail++; $display("FAIL clrlap_setup%0d cyc%0d: got %h want %h", k, c, obs_w, exp_vec());
                end
            end
        end
        cnt_ones = 4'd4; cnt_tens = 4'd1;
        #2;
        clr = 1'b1;
        #1;
        n_cmp++;
        if ({cnt_en, cnt_clr, running, disp_sel, disp_tens, disp_ones} !== 12'h414) begin
            n_fail++; $display("FAIL clr_in_lap: got %h want 414", {cnt_en, cnt_clr, running, disp_sel, disp_tens, disp_ones});
        end
        model_reset();
        step();
        clr = 1'b0;
        step();
        n_cmp++;
        if (obs_w !== exp_vec()) begin
            n_fail++; $display("FAIL clr_release: got %h want %h", obs_w, exp_vec());
        end
    endtask

    task automatic test_random();
        int sl, ll;
        apply_reset();
        sl = 1; ll = 1;
        for (int c = 0; c < 900; c++) begin
            sl = sl - 1;
            ll = ll - 1;
            if (sl == 0) begin btn_start = ~btn_start; sl = $urandom_range(16, 1); end
            if (ll == 0) begin btn_lap = ~btn_lap; ll = $urandom_range(20, 1); end
            cnt_ones = 4'($urandom_range(9, 0));
            cnt_tens = 4'($urandom_range(5, 0));
            step();
            n_cmp++;
            if (obs_w !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc%0d: got %h want %h", c, obs_w, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_bounce();
        test_lap();
        test_pause();
        test_simul();
        test_clr_lap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
